// File: rtl/send_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// send_arbiter_pkg : state encoding and frame sizing shared by the send arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package send_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STREAM  = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  localparam int FRAME_OVERHEAD      = 5;
  localparam int FRAME_LEN_LIMIT     = 64;
  // Largest payload keeping the frame length byte below FRAME_LEN_LIMIT.
  localparam int DEFAULT_MAX_PAYLOAD = FRAME_LEN_LIMIT - 1 - FRAME_OVERHEAD;
  localparam int GRANT_W             = 3;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first request after last_grant
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] next_grant,
  output logic             any_req
);

  int w_dist;
  int w_best;

  always_comb begin
    next_grant = last_grant;
    any_req    = |req;
    w_best     = NREQ;
    w_dist     = 0;
    // Distance 0 is the requester right after the last grant; smallest wins.
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + 2 * NREQ - 1 - int'(last_grant)) % NREQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        next_grant = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/send_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// send_arbiter : round-robin share of the framing send ring and length FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
module send_arbiter
  import send_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int LEN_BITS    = 8,
  parameter int MAX_PAYLOAD = DEFAULT_MAX_PAYLOAD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [7:0]           send_ring_data,
  output logic                 send_ring_wr_en,
  input  logic                 send_ring_full,
  output logic [LEN_BITS-1:0]  send_fifo_data,
  output logic                 send_fifo_wr_en,
  input  logic                 send_fifo_full,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [GRANT_W-1:0]  r_grant;
  logic [GRANT_W-1:0]  w_pick;
  logic                w_any;
  logic [LEN_BITS-1:0] r_count;
  logic [LEN_BITS-1:0] r_len;
  logic [LEN_BITS-1:0] w_count_inc;
  logic                w_hit_max;
  logic                r_discard_pend;
  logic                r_overflow;
  logic [NREQ-1:0]     w_onehot;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [7:0]          w_sel_data;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (GRANT_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (r_grant),
    .next_grant (w_pick),
    .any_req    (w_any)
  );

  always_comb begin
    w_onehot    = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == GRANT_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*8 +: 8];
      end
    end
  end

  assign w_count_inc = r_count + 1'b1;
  assign w_hit_max   = (w_count_inc == LEN_BITS'(MAX_PAYLOAD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next_state = ST_STREAM;
      end
      ST_STREAM: begin
        if (send_ring_wr_en && (w_sel_last || w_hit_max)) w_next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (!send_fifo_full) w_next_state = r_discard_pend ? ST_DISCARD : ST_IDLE;
      end
      ST_DISCARD: begin
        if (w_sel_valid && w_sel_last) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready       = '0;
    send_ring_wr_en = 1'b0;
    send_fifo_wr_en = 1'b0;
    case (r_state)
      ST_STREAM: begin
        req_ready       = send_ring_full ? '0 : w_onehot;
        send_ring_wr_en = w_sel_valid & ~send_ring_full;
      end
      ST_COMMIT: begin
        send_fifo_wr_en = ~send_fifo_full;
      end
      ST_DISCARD: begin
        req_ready = w_onehot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant        <= GRANT_W'(NREQ - 1);
      r_count        <= '0;
      r_len          <= '0;
      r_discard_pend <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_grant <= w_pick;
        r_count <= '0;
      end
      if (r_state == ST_STREAM && send_ring_wr_en) begin
        r_count <= w_count_inc;
        if (w_sel_last || w_hit_max) r_len <= w_count_inc;
        if (w_hit_max && !w_sel_last) r_discard_pend <= 1'b1;
      end
      if (r_state == ST_COMMIT && !send_fifo_full) r_discard_pend <= 1'b0;
      // A fresh overflow event takes priority over a same-cycle clear.
      if (r_state == ST_STREAM && send_ring_wr_en && w_hit_max && !w_sel_last) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign send_ring_data = w_sel_data;
  assign send_fifo_data = r_len;
  assign grant_id       = r_grant;
  assign busy           = (r_state != ST_IDLE);
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_send_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_send_arbiter : queue-based message model checked against send_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_send_arbiter;

  localparam int NREQ = 4;
  localparam int LEN_BITS = 8;
  localparam int MAXP = 58;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic [7:0]          send_ring_data;
  logic                send_ring_wr_en;
  logic                send_ring_full;
  logic [LEN_BITS-1:0] send_fifo_data;
  logic                send_fifo_wr_en;
  logic                send_fifo_full;
  logic [2:0]          grant_id;
  logic                busy;
  logic                overflow;
  logic                overflow_clr;

  send_arbiter #(.NREQ(NREQ), .LEN_BITS(LEN_BITS), .MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .send_ring_data(send_ring_data),
    .send_ring_wr_en(send_ring_wr_en), .send_ring_full(send_ring_full),
    .send_fifo_data(send_fifo_data), .send_fifo_wr_en(send_fifo_wr_en),
    .send_fifo_full(send_fifo_full), .grant_id(grant_id), .busy(busy),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pending bytes per requester, {last, data}; expected ring bytes {ovf_trigger, data}.
  logic [8:0] bq [NREQ][$];
  logic [8:0] exp_ring [$];
  logic [7:0] exp_len [$];
  logic [7:0] ring_log [$];
  logic [7:0] len_log [$];
  int         grant_log [$];
  int         m_grant;
  bit         m_discard;
  bit         m_ovf;
  bit         model_en;
  int         n_checks;
  int         n_errors;
  int         phase, cyc, hold_cnt;
  int         gap_pct, ring_full_pct, fifo_full_pct, clr_pct;
  bit         clr_force;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return last;
  endfunction

  always @(negedge clk) begin : cmp
    bit active, streaming, committing, discarding, trig, exp_rwr, exp_fwr, was_last;
    int g, p, n, keep;
    logic [NREQ-1:0] onehot, exp_ready;
    if (model_en && !rst) begin
      active     = (exp_len.size() != 0) || m_discard;
      streaming  = exp_ring.size() != 0;
      committing = !streaming && (exp_len.size() != 0);
      discarding = m_discard && !streaming && !committing;
      g          = m_grant;
      onehot     = NREQ'(1) << g;
      exp_ready  = streaming ? (send_ring_full ? '0 : onehot) : (discarding ? onehot : '0);
      exp_rwr    = streaming && req_valid[g] && !send_ring_full;
      exp_fwr    = committing && !send_fifo_full;
      chk("busy", int'(busy), int'(active));
      chk("grant_id", int'(grant_id), g);
      chk("req_ready", int'(req_ready), int'(exp_ready));
      chk("ring_wr_en", int'(send_ring_wr_en), int'(exp_rwr));
      chk("fifo_wr_en", int'(send_fifo_wr_en), int'(exp_fwr));
      chk("overflow", int'(overflow), int'(m_ovf));
      trig = 1'b0;
      if (send_ring_wr_en && exp_rwr) begin
        chk("ring_data", int'(send_ring_data), int'(exp_ring[0][7:0]));
        trig = exp_ring[0][8];
        ring_log.push_back(send_ring_data);
        void'(exp_ring.pop_front());
      end
      if (send_fifo_wr_en && exp_fwr) begin
        chk("fifo_data", int'(send_fifo_data), int'(exp_len[0]));
        len_log.push_back(send_fifo_data);
        void'(exp_len.pop_front());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && bq[i].size() != 0) begin
          was_last = bq[i][0][8];
          void'(bq[i].pop_front());
          if (discarding && i == g && was_last) m_discard = 1'b0;
        end
      end
      if (!active && req_valid != '0) begin
        p = rr_next(m_grant, req_valid);
        m_grant = p;
        grant_log.push_back(p);
        n = 0;
        for (int k = 0; k < bq[p].size(); k++) begin
          n++;
          if (bq[p][k][8]) break;
        end
        keep = (n > MAXP) ? MAXP : n;
        for (int k = 0; k < keep; k++) exp_ring.push_back({(n > MAXP) && (k == MAXP - 1), bq[p][k][7:0]});
        exp_len.push_back(8'(keep));
        m_discard = (n > MAXP);
      end
      m_ovf = trig ? 1'b1 : (overflow_clr ? 1'b0 : m_ovf);
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (bq[i].size() != 0) && ($urandom_range(0, 99) >= gap_pct);
      req_data[i*8 +: 8] = (bq[i].size() != 0) ? bq[i][0][7:0] : 8'h00;
      req_last[i] = (bq[i].size() != 0) ? bq[i][0][8] : 1'b0;
    end
    if (phase == 4) begin
      send_ring_full = (ring_log.size() >= 2) && (hold_cnt < 5);
      if (send_ring_full) hold_cnt++;
    end else begin
      send_ring_full = $urandom_range(0, 99) < ring_full_pct;
    end
    send_fifo_full = (phase == 5) ? (cyc < 8) : ($urandom_range(0, 99) < fifo_full_pct);
    overflow_clr   = clr_force || ($urandom_range(0, 99) < clr_pct);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    cyc++;
  endtask

  task automatic run_phase(input int max_cycles);
    bit done;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < max_cycles) begin
      step();
      done = (exp_ring.size() == 0) && (exp_len.size() == 0) && !m_discard;
      for (int i = 0; i < NREQ; i++) if (bq[i].size() != 0) done = 1'b0;
    end
    if (!done) chk("phase_timeout", 0, 1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    model_en = 1'b0;
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    send_ring_full = 1'b0; send_fifo_full = 1'b0; overflow_clr = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), NREQ - 1);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_strobes", int'({req_ready, send_ring_wr_en, send_fifo_wr_en}), 0);
    for (int i = 0; i < NREQ; i++) bq[i].delete();
    exp_ring.delete(); exp_len.delete();
    ring_log.delete(); len_log.delete(); grant_log.delete();
    m_grant = NREQ - 1; m_discard = 1'b0; m_ovf = 1'b0;
    hold_cnt = 0; clr_force = 1'b0;
    gap_pct = 0; ring_full_pct = 0; fifo_full_pct = 0; clr_pct = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_en = 1'b1;
  endtask

  task automatic push_msg(input int i, input int n, input int base);
    for (int k = 0; k < n; k++) bq[i].push_back({k == n - 1, 8'(base + k)});
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; model_en = 1'b0; phase = 0;

    phase = 1;
    do_reset();
    bq[0].push_back({1'b0, 8'h11}); bq[0].push_back({1'b0, 8'h22}); bq[0].push_back({1'b1, 8'h33});
    run_phase(200);
    chk("p1_ring_count", ring_log.size(), 3);
    if (ring_log.size() == 3) begin
      chk("p1_ring0", int'(ring_log[0]), 'h11);
      chk("p1_ring1", int'(ring_log[1]), 'h22);
      chk("p1_ring2", int'(ring_log[2]), 'h33);
    end
    chk("p1_len_count", len_log.size(), 1);
    if (len_log.size() == 1) chk("p1_len", int'(len_log[0]), 3);
    chk("p1_grant_id", int'(grant_id), 0);
    chk("p1_busy", int'(busy), 0);

    phase = 2;
    do_reset();
    push_msg(1, 2, 'hA1);
    push_msg(2, 3, 'hB1);
    run_phase(200);
    chk("p2_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("p2_grant0", grant_log[0], 1);
      chk("p2_grant1", grant_log[1], 2);
    end
    chk("p2_len_count", len_log.size(), 2);
    if (len_log.size() == 2) begin
      chk("p2_len0", int'(len_log[0]), 2);
      chk("p2_len1", int'(len_log[1]), 3);
    end
    if (ring_log.size() == 5) begin
      chk("p2_ring0", int'(ring_log[0]), 'hA1);
      chk("p2_ring2", int'(ring_log[2]), 'hB1);
    end else chk("p2_ring_count", ring_log.size(), 5);

    phase = 3;
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NREQ; i++) push_msg(i, 1, 16 * i + r);
    run_phase(300);
    chk("p3_grant_count", grant_log.size(), 2 * NREQ);
    if (grant_log.size() == 2 * NREQ) begin
      for (int k = 0; k < 2 * NREQ; k++) chk("p3_grant_order", grant_log[k], k % NREQ);
    end

    phase = 4;
    do_reset();
    push_msg(0, 6, 'h40);
    run_phase(200);
    chk("p4_full_cycles", hold_cnt, 5);
    chk("p4_len_count", len_log.size(), 1);
    if (len_log.size() == 1) chk("p4_len", int'(len_log[0]), 6);

    phase = 5;
    do_reset();
    push_msg(0, 2, 'h50);
    push_msg(1, 2, 'h60);
    run_phase(200);
    chk("p5_len_count", len_log.size(), 2);
    if (len_log.size() == 2) begin
      chk("p5_len0", int'(len_log[0]), 2);
      chk("p5_len1", int'(len_log[1]), 2);
    end

    phase = 6;
    do_reset();
    push_msg(0, 60, 1);
    run_phase(400);
    chk("p6_ring_count", ring_log.size(), MAXP);
    if (ring_log.size() == MAXP) chk("p6_ring_last", int'(ring_log[MAXP-1]), MAXP);
    chk("p6_len_count", len_log.size(), 1);
    if (len_log.size() == 1) chk("p6_len", int'(len_log[0]), MAXP);
    chk("p6_overflow_set", int'(overflow), 1);
    clr_force = 1'b1;
    step();
    clr_force = 1'b0;
    step();
    chk("p6_overflow_clr", int'(overflow), 0);

    phase = 7;
    gap_pct = 30; ring_full_pct = 20; fifo_full_pct = 30; clr_pct = 3;
    for (int i = 0; i < NREQ; i++) begin
      for (int m = 0; m < 6; m++) begin
        push_msg(i, ($urandom_range(0, 7) == 0) ? $urandom_range(56, 62) : $urandom_range(1, 10),
                 $urandom_range(0, 255));
      end
    end
    run_phase(20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/send_arbiter.md
Name: send_arbiter

Overview:
- Shares the framing send path (payload byte ring plus length FIFO) between NREQ independent message producers.
- Each producer streams one message as bytes terminated by a last flag.
- The arbiter grants one producer at a time in round-robin order and forwards its bytes into the send ring.
- On the final byte it pushes the payload length into the length FIFO, so each message becomes exactly one transmitted frame.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN_BITS, 8, width of the length word written to the length FIFO.
- MAX_PAYLOAD, 58, maximum payload bytes per frame (frame length byte must stay < 64).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*NREQ  packed payload bytes.
- req_last  in  NREQ  byte on requester i is the last of its message.
- req_ready  out  NREQ  byte accepted this cycle when req_valid[i] & req_ready[i].
- send_ring_data  out  8  byte to the framing send ring.
- send_ring_wr_en  out  1  ring write strobe.
- send_ring_full  in  1  ring full.
- send_fifo_data  out  LEN_BITS  payload length of the completed message.
- send_fifo_wr_en  out  1  length FIFO write strobe.
- send_fifo_full  in  1  length FIFO full.
- grant_id  out  3  index of the current/last granted requester.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky; a message exceeded MAX_PAYLOAD.
- overflow_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: state IDLE, grant_id = NREQ-1 (so requester 0 wins first), byte count 0, overflow 0, all strobes and req_ready 0.
- States: IDLE, STREAM, COMMIT, DISCARD.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from grant_id+1 upward with wrap.
  - Register it as grant_id, clear the count, go to STREAM next cycle.
  - req_ready is all zero in IDLE; one cycle of arbitration latency.
- STREAM:
  - req_ready[g] = !send_ring_full; all other req_ready bits are 0.
  - send_ring_wr_en = req_valid[g] & !send_ring_full; send_ring_data = req_data[g].
  - These are combinational; send_ring_wr_en is never asserted while full.
  - On each accepted byte, count increments (LEN_BITS wide, no wrap within MAX_PAYLOAD).
  - If the accepted byte has req_last, or count+1 == MAX_PAYLOAD: latch len = count+1 and go to COMMIT.
  - If MAX_PAYLOAD is reached without req_last: set overflow and mark discard-pending.
  - If last and the MAX_PAYLOAD limit hit on the same byte, this is a normal completion: no overflow.
- COMMIT:
  - send_fifo_wr_en = !send_fifo_full; send_fifo_data = len.
  - Hold until the write happens, then go to DISCARD if discard-pending, otherwise IDLE.
  - The length is always written after every byte of its message is in the ring.
- DISCARD:
  - req_ready[g] = 1; bytes are consumed and dropped.
  - On the accepted byte with req_last, go to IDLE.
- Requester i deasserting req_valid mid-message: the arbiter holds the grant and waits; there is no timeout.
- No zero-length messages; every message carries at least one byte.
- overflow_clr and a new overflow event in the same cycle: set wins.
- Async rst mid-message: all state is cleared immediately. Bytes already in the ring without a committed length are the framing owner's problem; the system resets both together.
- grant_id stays valid in IDLE and reflects the last granted requester.

Decomposition:
- Shared package holds the state encoding (2-bit constants ST_IDLE/ST_STREAM/ST_COMMIT/ST_DISCARD) and the frame overhead constant (5) from which MAX_PAYLOAD is derived.
- One natural sub-module: rr_pick, a combinational round-robin priority picker (inputs: request vector, last grant; output: next grant index, any-request flag).
- rr_pick is reusable by other arbiters in the design.

Test Plan:
- Single requester 0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) -> ring gets 11,22,33 in order, then one length write 0x03, grant_id=0, busy back to 0.
- Requesters 1 and 2 both valid from reset -> 1 granted first, 2 second; ring contains 1's bytes then 2's; length FIFO gets the two lengths in the same order.
- All 4 requesters continuously valid with 1-byte messages -> grants cycle 0,1,2,3,0 with no requester starved.
- send_ring_full held high for 5 cycles mid-message -> req_ready and send_ring_wr_en stay 0; the message completes intact afterwards with the correct length.
- send_fifo_full high when the last byte arrives -> stays in COMMIT, no byte from any requester is accepted, length is written on the first cycle full drops.
- Requester sends 60 bytes with last on byte 60 -> 58 bytes written, length 58, overflow=1, bytes 59-60 dropped; overflow_clr pulse -> overflow=0.
